// File: rtl/bmp_pixel_fetch_ctrl_pkg.sv
// ============================================================================
// Module   : bmp_pixel_fetch_ctrl_pkg
// Brief    : Shared constants and fetch FSM encoding for the BMP pixel fetcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bmp_pixel_fetch_ctrl_pkg;

    localparam int BMP_HDR_BYTES = 54;
    localparam int BYTES_PER_PIX = 3;

    // Byte lanes double as the address offset within a pixel triplet.
    localparam int LANE_B = 0;
    localparam int LANE_G = 1;
    localparam int LANE_R = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_CAP  = 3'd4,
        ST_OUT  = 3'd5
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/bmp_pixel_fetch_ctrl_addr_calc.sv
// ============================================================================
// Module   : bmp_addr_calc
// Brief    : Combinational (x,y) -> BMP byte address of the pixel's B byte,
//            plus an in-range flag. Rows are stored bottom-up.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bmp_addr_calc
    import bmp_pixel_fetch_ctrl_pkg::*;
#(
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 192,
    parameter int BF_OFFSET = BMP_HDR_BYTES,
    parameter int ADDR_W    = 18
) (
    input  logic [9:0]        x_i,
    input  logic [8:0]        y_i,
    output logic [ADDR_W-1:0] base_o,
    output logic              in_range_o
);

    localparam int PW = ADDR_W + 2;

    logic [PW-1:0] w_row;
    logic [PW-1:0] w_lin;

    assign w_row  = PW'(IMG_H - 1) - PW'(y_i);
    assign w_lin  = w_row * PW'(IMG_W) + PW'(x_i);
    assign base_o = ADDR_W'(PW'(BF_OFFSET) + w_lin * PW'(BYTES_PER_PIX));

    assign in_range_o = (32'(x_i) < 32'(IMG_W)) && (32'(y_i) < 32'(IMG_H));

endmodule

`default_nettype wire

// File: rtl/bmp_pixel_fetch_ctrl.sv
// ============================================================================
// Module   : bmp_pixel_fetch_ctrl
// Brief    : Turns (x,y) pixel requests into three byte reads of a 24-bit BMP
//            and shares the memory port with a writer under a starvation guard.
//            Optional macro BMP_LAST_PIX_CACHE_EN adds a last-pixel cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bmp_pixel_fetch_ctrl
    import bmp_pixel_fetch_ctrl_pkg::*;
#(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 192,
    parameter int BF_OFFSET  = BMP_HDR_BYTES,
    parameter int ADDR_W     = 18,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_req_valid,
    output logic              pix_req_ready,
    input  logic [9:0]        pix_x,
    input  logic [8:0]        pix_y,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_rgb,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        b_q, g_q;
    logic [23:0]       rgb_q;
    logic [CNT_W-1:0]  starve_q;

    logic [ADDR_W-1:0] w_base;
    logic              w_in_range;
    logic              w_idle;
    logic              w_starved;
    logic              w_wr_wins;
    logic              w_wr_grant;
    logic              w_pix_ready;
    logic              w_pix_accept;
    logic              w_hit;
    logic [23:0]       w_hit_rgb;

    bmp_addr_calc #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .BF_OFFSET (BF_OFFSET),
        .ADDR_W    (ADDR_W)
    ) u_addr_calc (
        .x_i        (pix_x),
        .y_i        (pix_y),
        .base_o     (w_base),
        .in_range_o (w_in_range)
    );

    // The write takes the port when no pixel is pending or the pixel side has
    // used up its allowance of consecutive grants.
    assign w_idle       = rst_n && (state_q == ST_IDLE);
    assign w_starved    = (starve_q == CNT_W'(STARVE_MAX));
    assign w_wr_wins    = wr_valid && (!pix_req_valid || w_starved);
    assign w_wr_grant   = w_idle && w_wr_wins;
    assign w_pix_ready  = w_idle && !w_wr_wins;
    assign w_pix_accept = w_pix_ready && pix_req_valid;

`ifdef BMP_LAST_PIX_CACHE_EN
    logic        cache_vld_q;
    logic [9:0]  cache_x_q, req_x_q;
    logic [8:0]  cache_y_q, req_y_q;
    logic [23:0] cache_rgb_q;

    assign w_hit     = cache_vld_q && (cache_x_q == pix_x) && (cache_y_q == pix_y);
    assign w_hit_rgb = cache_rgb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cache_vld_q <= 1'b0;
            cache_x_q   <= '0;
            cache_y_q   <= '0;
            cache_rgb_q <= '0;
            req_x_q     <= '0;
            req_y_q     <= '0;
        end else begin
            if (w_wr_grant) begin
                cache_vld_q <= 1'b0;
            end
            if (w_pix_accept) begin
                req_x_q <= pix_x;
                req_y_q <= pix_y;
            end
            if (state_q == ST_CAP) begin
                cache_vld_q <= 1'b1;
                cache_x_q   <= req_x_q;
                cache_y_q   <= req_y_q;
                cache_rgb_q <= {mem_rdata, g_q, b_q};
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_rgb = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pix_accept) begin
                    state_d = (!w_in_range || w_hit) ? ST_OUT : ST_RD0;
                end
            end
            ST_RD0:  state_d = ST_RD1;
            ST_RD1:  state_d = ST_RD2;
            ST_RD2:  state_d = ST_CAP;
            ST_CAP:  state_d = ST_OUT;
            ST_OUT: begin
                if (pix_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        pix_valid     = 1'b0;
        pix_req_ready = w_pix_ready;
        wr_ready      = w_wr_grant;
        if (rst_n) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_wr_grant) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = wr_addr;
                        mem_wdata = wr_data;
                    end
                end
                ST_RD0: begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + ADDR_W'(LANE_B);
                end
                ST_RD1: begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + ADDR_W'(LANE_G);
                end
                ST_RD2: begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + ADDR_W'(LANE_R);
                end
                ST_OUT:  pix_valid = 1'b1;
                default: ;
            endcase
        end
    end

    // Read data trails the address by one cycle, so each byte is captured in
    // the state after the one that issued it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q   <= '0;
            b_q      <= '0;
            g_q      <= '0;
            rgb_q    <= '0;
            starve_q <= '0;
        end else begin
            if (w_pix_accept) begin
                base_q <= w_base;
                if (!w_in_range) begin
                    rgb_q <= '0;
                end else if (w_hit) begin
                    rgb_q <= w_hit_rgb;
                end
            end
            if (state_q == ST_RD1) begin
                b_q <= mem_rdata;
            end
            if (state_q == ST_RD2) begin
                g_q <= mem_rdata;
            end
            if (state_q == ST_CAP) begin
                rgb_q <= {mem_rdata, g_q, b_q};
            end
            if (!wr_valid || w_wr_grant) begin
                starve_q <= '0;
            end else if (w_pix_accept && !w_starved) begin
                starve_q <= starve_q + CNT_W'(1);
            end
        end
    end

    assign pix_rgb = rgb_q;

endmodule

`default_nettype wire
